// File: rtl/recog_frame_scheduler.sv
// Frame sequencer for the digit recogniser: freezes the locator box per frame, samples the
// crossing counts after vsync settles, classifies them and hands the digit out over valid/ready.
// Optional cross-frame debounce of the digit is enabled with `define RECOG_VOTE_EN.
module recog_frame_scheduler #(
  parameter int unsigned SETTLE_CYC    = 4,
  parameter logic [10:0] MIN_W         = 11'd16,
  parameter logic [10:0] MIN_H         = 11'd24,
  parameter int unsigned STABLE_FRAMES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vsync,
  input  logic        box_valid,
  input  logic [10:0] box_top,
  input  logic [10:0] box_bottom,
  input  logic [10:0] box_left,
  input  logic [10:0] box_right,
  output logic [10:0] line_top,
  output logic [10:0] line_bottom,
  output logic [10:0] line_left,
  output logic [10:0] line_right,
  input  logic [3:0]  v_cnt,
  input  logic [3:0]  h_cnt1,
  input  logic [3:0]  h_cnt2,
  input  logic        h1,
  input  logic        h2,
  output logic [3:0]  digit,
  output logic        digit_valid,
  input  logic        digit_ready,
  output logic        overrun
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StActive   = 3'd1;
  localparam logic [2:0] StSettle   = 3'd2;
  localparam logic [2:0] StClassify = 3'd3;
  localparam logic [2:0] StEmit     = 3'd4;
  localparam logic [2:0] StWait     = 3'd5;

  localparam logic [7:0] SettleLast = 8'(SETTLE_CYC - 1);

  logic [2:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        vsync_q;
  logic        rise, fall;
  logic        load_box, sample, do_classify, do_emit, publish;
  logic        box_ok_q, box_ok_d;
  logic [10:0] box_w, box_h;
  logic [3:0]  v_s_q, c1_s_q, c2_s_q;
  logic        h1_s_q, h2_s_q;
  logic [3:0]  cls_q;

  assign rise = vsync & ~vsync_q;
  assign fall = ~vsync & vsync_q;

  assign box_w    = box_right - box_left;
  assign box_h    = box_bottom - box_top;
  // Inverted boxes wrap to large widths, so reject them explicitly.
  assign box_ok_d = box_valid & (box_right >= box_left) & (box_bottom >= box_top) &
                    (box_w >= MIN_W) & (box_h >= MIN_H);

  function automatic logic [3:0] classify(input logic ok, input logic [3:0] v,
                                          input logic [3:0] c1, input logic [3:0] c2,
                                          input logic l1, input logic l2);
    logic [3:0] res;
    res = 4'hF;
    if (!ok)                                                          res = 4'hF;
    else if (v == 4'd2 && c1 == 4'd2 && c2 == 4'd2)                   res = 4'd0;
    else if (v == 4'd1 && c1 == 4'd1 && c2 == 4'd1)                   res = 4'd1;
    else if (v == 4'd3 && c1 == 4'd1 && !l1 && c2 == 4'd1 && l2)      res = 4'd2;
    else if (v == 4'd3 && c1 == 4'd1 && !l1 && c2 == 4'd1 && !l2)     res = 4'd3;
    else if (v == 4'd2 && c1 == 4'd2 && c2 == 4'd1 && !l2)            res = 4'd4;
    else if (v == 4'd3 && c1 == 4'd1 && l1 && c2 == 4'd1 && !l2)      res = 4'd5;
    else if (v == 4'd3 && c1 == 4'd1 && l1 && c2 == 4'd2)             res = 4'd6;
    else if (v == 4'd2 && c1 == 4'd1 && c2 == 4'd1)                   res = 4'd7;
    else if (v == 4'd3 && c1 == 4'd2 && c2 == 4'd2)                   res = 4'd8;
    else if (v == 4'd3 && c1 == 4'd2 && c2 == 4'd1 && !l2)            res = 4'd9;
    return res;
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    load_box    = 1'b0;
    sample      = 1'b0;
    do_classify = 1'b0;
    do_emit     = 1'b0;
    case (state_q)
      StIdle: begin
        if (rise) begin
          state_d  = StActive;
          load_box = 1'b1;
        end
      end
      StActive: begin
        if (fall) begin
          state_d = StSettle;
          cnt_d   = 8'd0;
        end
      end
      StSettle: begin
        // A vsync rise before settling abandons the frame.
        if (rise) begin
          state_d  = StActive;
          load_box = 1'b1;
        end else if (cnt_q == SettleLast) begin
          state_d = StClassify;
          sample  = 1'b1;
        end else if (!vsync) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StClassify: begin
        do_classify = 1'b1;
        state_d     = StEmit;
      end
      StEmit: begin
        do_emit = 1'b1;
        state_d = StWait;
      end
      StWait: begin
        if (rise) begin
          state_d  = StActive;
          load_box = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef RECOG_VOTE_EN
  localparam logic [7:0] RunMax = 8'(STABLE_FRAMES);

  logic [3:0] cand_q, cand_d;
  logic [7:0] run_q, run_d;

  always_comb begin
    cand_d = cand_q;
    run_d  = run_q;
    if (do_emit) begin
      if (cls_q == cand_q) begin
        run_d = (run_q >= RunMax) ? RunMax : run_q + 8'd1;
      end else begin
        cand_d = cls_q;
        run_d  = 8'd1;
      end
    end
  end

  assign publish = do_emit & (run_d >= RunMax) & (cand_d != digit);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cand_q <= 4'hF;
      run_q  <= 8'd0;
    end else begin
      cand_q <= cand_d;
      run_q  <= run_d;
    end
  end
`else
  assign publish = do_emit;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      // Reset as if vsync were high so a frame in progress at release is skipped.
      vsync_q     <= 1'b1;
      box_ok_q    <= 1'b0;
      line_top    <= 11'd0;
      line_bottom <= 11'd0;
      line_left   <= 11'd0;
      line_right  <= 11'd0;
      v_s_q       <= 4'd0;
      c1_s_q      <= 4'd0;
      c2_s_q      <= 4'd0;
      h1_s_q      <= 1'b0;
      h2_s_q      <= 1'b0;
      cls_q       <= 4'hF;
      digit       <= 4'hF;
      digit_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vsync_q <= vsync;
      if (load_box) begin
        line_top    <= box_top;
        line_bottom <= box_bottom;
        line_left   <= box_left;
        line_right  <= box_right;
        box_ok_q    <= box_ok_d;
      end
      if (sample) begin
        v_s_q  <= v_cnt;
        c1_s_q <= h_cnt1;
        c2_s_q <= h_cnt2;
        h1_s_q <= h1;
        h2_s_q <= h2;
      end
      if (do_classify) begin
        cls_q <= classify(box_ok_q, v_s_q, c1_s_q, c2_s_q, h1_s_q, h2_s_q);
      end
      if (publish) begin
        digit       <= cls_q;
        digit_valid <= 1'b1;
        if (digit_valid && !digit_ready) overrun <= 1'b1;
      end else if (digit_valid && digit_ready) begin
        digit_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_recog_frame_scheduler.sv
// Directed bench for recog_frame_scheduler; the vote scenario runs when RECOG_VOTE_EN is defined.
module tb_recog_frame_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        vsync;
  logic        box_valid;
  logic [10:0] box_top, box_bottom, box_left, box_right;
  logic [10:0] line_top, line_bottom, line_left, line_right;
  logic [3:0]  v_cnt, h_cnt1, h_cnt2;
  logic        h1, h2;
  logic [3:0]  digit;
  logic        digit_valid;
  logic        digit_ready;
  logic        overrun;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  recog_frame_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .vsync      (vsync),
    .box_valid  (box_valid),
    .box_top    (box_top),
    .box_bottom (box_bottom),
    .box_left   (box_left),
    .box_right  (box_right),
    .line_top   (line_top),
    .line_bottom(line_bottom),
    .line_left  (line_left),
    .line_right (line_right),
    .v_cnt      (v_cnt),
    .h_cnt1     (h_cnt1),
    .h_cnt2     (h_cnt2),
    .h1         (h1),
    .h2         (h2),
    .digit      (digit),
    .digit_valid(digit_valid),
    .digit_ready(digit_ready),
    .overrun    (overrun)
  );

  // One frame: vsync high for 'high' cycles, then low with the given counts. The result must
  // not appear 5 cycles after the first low sample and must appear 6 cycles after it.
  task automatic run_frame(input logic [10:0] t, input logic [10:0] b, input logic [10:0] l,
                           input logic [10:0] r, input logic bv, input logic [3:0] v,
                           input logic [3:0] c1, input logic [3:0] c2, input logic s1,
                           input logic s2, input int high, input logic rdy_emit,
                           input logic pub, input logic [3:0] exp_d, input logic prev_v,
                           input logic [3:0] prev_d, input string name);
    logic       ev;
    logic [3:0] ed;
    @(negedge clk);
    box_top = t; box_bottom = b; box_left = l; box_right = r; box_valid = bv;
    v_cnt = 4'd0; h_cnt1 = 4'd0; h_cnt2 = 4'd0; h1 = 1'b0; h2 = 1'b0;
    vsync = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({line_top, line_bottom, line_left, line_right} !== {t, b, l, r}) begin
      n_fail++;
      $display("FAIL %s line: got %0d %0d %0d %0d want %0d %0d %0d %0d", name, line_top,
               line_bottom, line_left, line_right, t, b, l, r);
    end
    repeat (high - 1) @(negedge clk);
    vsync = 1'b0;
    v_cnt = v; h_cnt1 = c1; h_cnt2 = c2; h1 = s1; h2 = s2;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (digit_valid !== prev_v || digit !== prev_d) begin
      n_fail++;
      $display("FAIL %s early: got valid=%b digit=%h want valid=%b digit=%h", name,
               digit_valid, digit, prev_v, prev_d);
    end
    if (rdy_emit) digit_ready = 1'b1;
    @(negedge clk);
    if (rdy_emit) digit_ready = 1'b0;
    ev = pub ? 1'b1 : prev_v;
    ed = pub ? exp_d : prev_d;
    n_cmp++;
    if (digit_valid !== ev || digit !== ed) begin
      n_fail++;
      $display("FAIL %s result: got valid=%b digit=%h want valid=%b digit=%h", name,
               digit_valid, digit, ev, ed);
    end
  endtask

  task automatic accept(input string name);
    digit_ready = 1'b1;
    @(negedge clk);
    digit_ready = 1'b0;
    n_cmp++;
    if (digit_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s accept: got valid=%b want 0", name, digit_valid);
    end
  endtask

  task automatic check_overrun(input logic exp, input string name);
    n_cmp++;
    if (overrun !== exp) begin
      n_fail++;
      $display("FAIL %s overrun: got %b want %b", name, overrun, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; vsync = 1'b0; box_valid = 1'b0; digit_ready = 1'b0;
    box_top = 11'd0; box_bottom = 11'd0; box_left = 11'd0; box_right = 11'd0;
    v_cnt = 4'd0; h_cnt1 = 4'd0; h_cnt2 = 4'd0; h1 = 1'b0; h2 = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({line_top, line_bottom, line_left, line_right} !== 44'd0 || digit !== 4'hF ||
        digit_valid !== 1'b0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: got lines=%h digit=%h valid=%b ovr=%b want 0 F 0 0",
               {line_top, line_bottom, line_left, line_right}, digit, digit_valid, overrun);
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_digit2();
    run_frame(11'd100, 11'd300, 11'd200, 11'd260, 1'b1, 4'd3, 4'd1, 4'd1, 1'b0, 1'b1, 1000,
              1'b0, 1'b1, 4'd2, 1'b0, 4'hF, "digit2");
    check_overrun(1'b0, "digit2");
    accept("digit2");
  endtask

  task automatic test_box_limits();
    run_frame(11'd100, 11'd300, 11'd200, 11'd210, 1'b1, 4'd3, 4'd2, 4'd2, 1'b0, 1'b0, 50,
              1'b0, 1'b1, 4'hF, 1'b0, 4'd2, "narrow");
    accept("narrow");
    run_frame(11'd100, 11'd124, 11'd200, 11'd216, 1'b1, 4'd2, 4'd2, 4'd2, 1'b0, 1'b0, 20,
              1'b0, 1'b1, 4'd0, 1'b0, 4'hF, "min_box");
    accept("min_box");
    run_frame(11'd100, 11'd124, 11'd200, 11'd215, 1'b1, 4'd2, 4'd2, 4'd2, 1'b0, 1'b0, 20,
              1'b0, 1'b1, 4'hF, 1'b0, 4'd0, "w15");
    accept("w15");
    run_frame(11'd100, 11'd300, 11'd260, 11'd200, 1'b1, 4'd1, 4'd1, 4'd1, 1'b0, 1'b0, 20,
              1'b0, 1'b1, 4'hF, 1'b0, 4'hF, "inverted");
    accept("inverted");
    run_frame(11'd100, 11'd300, 11'd200, 11'd260, 1'b0, 4'd1, 4'd1, 4'd1, 1'b0, 1'b0, 20,
              1'b0, 1'b1, 4'hF, 1'b0, 4'hF, "no_box");
    accept("no_box");
  endtask

  task automatic test_overrun();
    run_frame(11'd100, 11'd300, 11'd200, 11'd260, 1'b1, 4'd3, 4'd1, 4'd1, 1'b0, 1'b0, 30,
              1'b0, 1'b1, 4'd3, 1'b0, 4'hF, "ovr_first");
    check_overrun(1'b0, "ovr_first");
    run_frame(11'd100, 11'd300, 11'd200, 11'd260, 1'b1, 4'd3, 4'd1, 4'd1, 1'b1, 1'b0, 30,
              1'b0, 1'b1, 4'd5, 1'b1, 4'd3, "ovr_second");
    check_overrun(1'b1, "ovr_second");
    accept("ovr_second");
    check_overrun(1'b1, "ovr_sticky");
  endtask

  task automatic test_abort();
    @(negedge clk);
    box_top = 11'd10; box_bottom = 11'd100; box_left = 11'd10; box_right = 11'd100;
    box_valid = 1'b1; vsync = 1'b1;
    repeat (20) @(negedge clk);
    vsync = 1'b0;
    v_cnt = 4'd1; h_cnt1 = 4'd1; h_cnt2 = 4'd1;
    repeat (2) @(negedge clk);
    box_top = 11'd50; box_bottom = 11'd200; box_left = 11'd60; box_right = 11'd120;
    vsync = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({line_top, line_bottom, line_left, line_right} !== {11'd50, 11'd200, 11'd60, 11'd120}
        || digit_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort reload: got %0d %0d %0d %0d valid=%b want 50 200 60 120 valid=0",
               line_top, line_bottom, line_left, line_right, digit_valid);
    end
    repeat (30) @(negedge clk);
    n_cmp++;
    if (digit_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort no_result: got valid=%b want 0", digit_valid);
    end
    vsync = 1'b0;
    v_cnt = 4'd2; h_cnt1 = 4'd1; h_cnt2 = 4'd1;
    repeat (7) @(negedge clk);
    n_cmp++;
    if (digit_valid !== 1'b1 || digit !== 4'd7) begin
      n_fail++;
      $display("FAIL abort resume: got valid=%b digit=%h want valid=1 digit=7", digit_valid,
               digit);
    end
    accept("abort");
  endtask

  task automatic test_reset_mid_settle();
    @(negedge clk);
    box_top = 11'd100; box_bottom = 11'd300; box_left = 11'd200; box_right = 11'd260;
    box_valid = 1'b1; vsync = 1'b1;
    repeat (10) @(negedge clk);
    vsync = 1'b0;
    v_cnt = 4'd2; h_cnt1 = 4'd2; h_cnt2 = 4'd1; h1 = 1'b0; h2 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({line_top, line_bottom, line_left, line_right} !== 44'd0 || digit !== 4'hF ||
        digit_valid !== 1'b0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got lines=%h digit=%h valid=%b ovr=%b want 0 F 0 0",
               {line_top, line_bottom, line_left, line_right}, digit, digit_valid, overrun);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (digit_valid !== 1'b0 || digit !== 4'hF) begin
      n_fail++;
      $display("FAIL mid_reset idle: got valid=%b digit=%h want valid=0 digit=F", digit_valid,
               digit);
    end
    run_frame(11'd100, 11'd300, 11'd200, 11'd260, 1'b1, 4'd2, 4'd2, 4'd1, 1'b0, 1'b0, 20,
              1'b0, 1'b1, 4'd4, 1'b0, 4'hF, "after_reset");
  endtask

  task automatic test_back_to_back();
    run_frame(11'd100, 11'd300, 11'd200, 11'd260, 1'b1, 4'd3, 4'd2, 4'd1, 1'b0, 1'b0, 20,
              1'b1, 1'b1, 4'd9, 1'b1, 4'd4, "b2b");
    check_overrun(1'b0, "b2b");
    @(negedge clk);
    n_cmp++;
    if (digit_valid !== 1'b1 || digit !== 4'd9) begin
      n_fail++;
      $display("FAIL b2b hold: got valid=%b digit=%h want valid=1 digit=9", digit_valid, digit);
    end
    accept("b2b");
  endtask

`ifdef RECOG_VOTE_EN
  task automatic test_vote();
    run_frame(11'd100, 11'd300, 11'd200, 11'd260, 1'b1, 4'd2, 4'd1, 4'd1, 1'b0, 1'b0, 20,
              1'b0, 1'b0, 4'd0, 1'b0, 4'hF, "vote_7a");
    run_frame(11'd100, 11'd300, 11'd200, 11'd260, 1'b1, 4'd2, 4'd1, 4'd1, 1'b0, 1'b0, 20,
              1'b0, 1'b0, 4'd0, 1'b0, 4'hF, "vote_7b");
    run_frame(11'd100, 11'd300, 11'd200, 11'd260, 1'b1, 4'd1, 4'd1, 4'd1, 1'b0, 1'b0, 20,
              1'b0, 1'b0, 4'd0, 1'b0, 4'hF, "vote_1a");
    run_frame(11'd100, 11'd300, 11'd200, 11'd260, 1'b1, 4'd1, 4'd1, 4'd1, 1'b0, 1'b0, 20,
              1'b0, 1'b0, 4'd0, 1'b0, 4'hF, "vote_1b");
    run_frame(11'd100, 11'd300, 11'd200, 11'd260, 1'b1, 4'd1, 4'd1, 4'd1, 1'b0, 1'b0, 20,
              1'b0, 1'b1, 4'd1, 1'b0, 4'hF, "vote_1c");
    accept("vote");
    run_frame(11'd100, 11'd300, 11'd200, 11'd260, 1'b1, 4'd1, 4'd1, 4'd1, 1'b0, 1'b0, 20,
              1'b0, 1'b0, 4'd0, 1'b0, 4'd1, "vote_same");
  endtask
`endif

  initial begin
    test_reset();
`ifdef RECOG_VOTE_EN
    test_vote();
`else
    test_digit2();
    test_box_limits();
    test_overrun();
    test_abort();
    test_reset_mid_settle();
    test_back_to_back();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/recog_frame_scheduler.md
Name: recog_frame_scheduler

Overview:
- Frame-level sequencer for the digit-recognition datapath.
- Latches the locator's bounding box at each frame start and drives it, frozen, to the intersection counter for the whole frame.
- After frame end, waits for the counter's result registers to settle, samples the crossing counts and classifies them into a digit 0-9.
- Optionally debounces the digit across frames, then presents it to the display/UART side with a valid/ready handshake.

Parameters:
- SETTLE_CYC, 4: clk cycles vsync must be low before the counts are sampled.
- MIN_W, 11'd16: minimum box width in pixels for a legal figure.
- MIN_H, 11'd24: minimum box height in pixels for a legal figure.
- STABLE_FRAMES, 3: consecutive identical classifications required before the output updates (only with RECOG_VOTE_EN).

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-low reset
- vsync  in  1  frame active high
- box_valid  in  1  locator found a figure in the last frame
- box_top/box_bottom/box_left/box_right  in  11 each  locator box
- line_top/line_bottom/line_left/line_right  out  11 each  frozen box to the counter
- v_cnt  in  4  vertical-divider crossings
- h_cnt1  in  4  upper horizontal-divider crossings
- h_cnt2  in  4  lower horizontal-divider crossings
- h1  in  1  last upper crossing was left of the vertical divider
- h2  in  1  last lower crossing was left of the vertical divider
- digit  out  4  recognised digit; 4'hF = none/unknown
- digit_valid  out  1  result available
- digit_ready  in  1  consumer accepts the result
- overrun  out  1  sticky; a result was overwritten before it was accepted

Behaviour:
- Reset (reset=0, async): all line_* = 0, digit = 4'hF, digit_valid = 0, overrun = 0, FSM in IDLE, settle counter = 0, vote state cleared.
- FSM states and transitions:
  - IDLE: go to ACTIVE on the first vsync rising edge (vsync sampled 0 then 1).
  - ACTIVE: at entry, in the same cycle as the rising edge, line_* <= box_*, and box_ok <= box_valid & (box_right-box_left >= MIN_W) & (box_bottom-box_top >= MIN_H). Subtractions are 11-bit unsigned; right<left or bottom<top forces box_ok = 0. On the vsync falling edge go to SETTLE with the counter cleared.
  - SETTLE: the counter increments each cycle vsync=0. When it reaches SETTLE_CYC-1, go to CLASSIFY. If vsync rises first, the frame is abandoned: no result, line_* reload, back to ACTIVE.
  - CLASSIFY (1 cycle): compute cls from registered samples, then go to EMIT.
  - EMIT (1 cycle): update digit/digit_valid per the rules below, then go to WAIT.
  - WAIT: go to ACTIVE on the vsync rising edge, with the box latched as in ACTIVE entry.
- Classification, first match wins, else 4'hF. L means h=1, R means h=0:
  - box_ok=0 -> F
  - v=2, h1c=2, h2c=2 -> 0
  - v=1, h1c=1, h2c=1 -> 1
  - v=3, h1c=1 R, h2c=1 L -> 2
  - v=3, h1c=1 R, h2c=1 R -> 3
  - v=2, h1c=2, h2c=1 R -> 4
  - v=3, h1c=1 L, h2c=1 R -> 5
  - v=3, h1c=1 L, h2c=2 -> 6
  - v=2, h1c=1, h2c=1 -> 7
  - v=3, h1c=2, h2c=2 -> 8
  - v=3, h1c=2, h2c=1 R -> 9
- Output handshake:
  - digit_valid rises in EMIT when a new digit is published.
  - It falls the cycle after a cycle with digit_valid & digit_ready.
  - digit is stable while valid.
  - If EMIT publishes while digit_valid=1 and not accepted that cycle: digit is overwritten, valid stays 1, overrun <= 1.
  - overrun clears only on reset.
  - Acceptance and EMIT in the same cycle: the new result wins, valid stays 1, no overrun.
- Total latency: result valid SETTLE_CYC+2 cycles after the vsync falling edge.

Optional Feature:
- Macro RECOG_VOTE_EN.
- Defined:
  - Hold cand (4b) and run (saturating counter).
  - In EMIT, cls==cand -> run++; otherwise cand <= cls, run <= 1.
  - Publish only when run reaches STABLE_FRAMES and cand != current digit; otherwise no valid pulse.
  - 4'hF is also voted.
- Undefined: every CLASSIFY result is published in EMIT unconditionally, even when equal to the previous digit.

Test Plan:
- Box (100,300,200,260) valid; vsync high 1000 cycles then low; counts v=3, h1c=1 R, h2c=1 L -> line_* = box during the frame; digit=2, valid asserted SETTLE_CYC+2 cycles after vsync fall.
- Box width 10 (<MIN_W) with counts of an 8 -> digit=F.
- Result held with digit_ready=0, next frame publishes 5 -> digit=5, overrun=1, valid stays 1; ready=1 -> valid drops the next cycle.
- vsync low for only 2 cycles -> no classification, no valid, line_* reloaded from the new box.
- RECOG_VOTE_EN, frames give 7,7,1,1,1 -> single publish of 1 after the fifth frame; no publish of 7.
- reset asserted mid-SETTLE -> outputs immediately at reset values; after release, no result until the next full frame.
